// File: rtl/mem_arbiter.sv
// Byte-serial RAM port owner: arbitrates LSB store/load and icache refill,
// sequences each grant as a burst of byte accesses and returns assembled data.
module mem_arbiter #(
    parameter int BLK_BYTES    = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   io_buffer_full,
    input  logic [7:0]             mem_din,
    output logic                   mem_rw,
    output logic [7:0]             mem_dout,
    output logic [31:0]            mem_aout,
    input  logic                   st_req,
    input  logic                   ld_req,
    input  logic [1:0]             lsb_width,
    input  logic [31:0]            lsb_addr,
    input  logic [31:0]            lsb_wdata,
    output logic                   st_done,
    output logic                   ld_done,
    output logic [31:0]            ld_rdata,
    input  logic                   if_req,
    input  logic [31:0]            if_addr,
    output logic                   if_done,
    output logic [8*BLK_BYTES-1:0] if_rdata
);
    localparam int BW = 8 * BLK_BYTES;
    localparam int CW = $clog2(BLK_BYTES) + 2;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;
    typedef enum logic [1:0] {K_ST = 2'd0, K_LD = 2'd1, K_IF = 2'd2} kind_t;

    state_t          state_q, state_d;
    kind_t           kind_q, kind_d;
    logic [31:0]     base_q, base_d;
    logic [CW-1:0]   n_q, n_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            io_q, io_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic            mem_rw_q, mem_rw_d;
    logic [7:0]      mem_dout_q, mem_dout_d;
    logic [31:0]     mem_aout_q, mem_aout_d;
    logic            st_done_q, st_done_d;
    logic            ld_done_q, ld_done_d;
    logic            if_done_q, if_done_d;
    logic [31:0]     ld_rdata_q, ld_rdata_d;
    logic [BW-1:0]   if_rdata_q, if_rdata_d;

    logic            fetch_first;
    logic            lsb_grant;
    logic [CW-1:0]   lsb_n;
    logic [CW-1:0]   nxt;

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        base_d      = base_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        io_d        = io_q;
        buf_d       = buf_q;
        mem_rw_d    = mem_rw_q;
        mem_dout_d  = mem_dout_q;
        mem_aout_d  = mem_aout_q;
        st_done_d   = 1'b0;
        ld_done_d   = 1'b0;
        if_done_d   = 1'b0;
        ld_rdata_d  = ld_rdata_q;
        if_rdata_d  = if_rdata_q;
        starve_d    = if_req ? starve_q : '0;
        fetch_first = if_req && (starve_q == SW'(STARVE_LIMIT));
        lsb_grant   = 1'b0;
        nxt         = cnt_q + CW'(1);
        case (lsb_width)
            2'd0:    lsb_n = CW'(1);
            2'd1:    lsb_n = CW'(2);
            default: lsb_n = CW'(4);
        endcase

        case (state_q)
            IDLE: begin
                if (st_req && !fetch_first) begin
                    lsb_grant  = 1'b1;
                    kind_d     = K_ST;
                    base_d     = lsb_addr;
                    n_d        = lsb_n;
                    wdata_d    = lsb_wdata;
                    io_d       = (lsb_addr[17:16] == 2'b11);
                    cnt_d      = '0;
                    mem_rw_d   = 1'b1;
                    mem_aout_d = lsb_addr;
                    mem_dout_d = lsb_wdata[7:0];
                    state_d    = WR;
                end else if (ld_req && !fetch_first) begin
                    lsb_grant  = 1'b1;
                    kind_d     = K_LD;
                    base_d     = lsb_addr;
                    n_d        = lsb_n;
                    io_d       = 1'b0;
                    cnt_d      = '0;
                    buf_d      = '0;
                    mem_rw_d   = 1'b0;
                    mem_aout_d = lsb_addr;
                    state_d    = RD;
                end else if (if_req) begin
                    kind_d     = K_IF;
                    base_d     = if_addr;
                    n_d        = CW'(BLK_BYTES);
                    io_d       = 1'b0;
                    cnt_d      = '0;
                    buf_d      = '0;
                    mem_rw_d   = 1'b0;
                    mem_aout_d = if_addr;
                    starve_d   = '0;
                    state_d    = RD;
                end
                if (lsb_grant && if_req && (starve_q < SW'(STARVE_LIMIT)))
                    starve_d = starve_q + SW'(1);
            end
            RD: begin
                // mem_din carries the byte addressed one cycle earlier
                if (cnt_q != '0) begin
                    for (int k = 0; k < BLK_BYTES; k++)
                        if ((cnt_q - CW'(1)) == CW'(k))
                            buf_d[8*k +: 8] = mem_din;
                end
                if (nxt < n_q) mem_aout_d = base_q + 32'(nxt);
                else           mem_aout_d = '0;
                if (cnt_q == n_q) begin
                    state_d = DONE;
                    if (kind_q == K_LD) begin
                        ld_done_d  = 1'b1;
                        ld_rdata_d = buf_d[31:0];
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = buf_d;
                    end
                end else begin
                    cnt_d = nxt;
                end
            end
            WR: begin
                if (!(io_q && io_buffer_full)) begin
                    if (nxt < n_q) begin
                        cnt_d      = nxt;
                        mem_aout_d = base_q + 32'(nxt);
                        mem_dout_d = 8'(wdata_q >> {nxt, 3'b000});
                    end else begin
                        mem_rw_d   = 1'b0;
                        mem_aout_d = '0;
                        mem_dout_d = '0;
                        st_done_d  = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q    <= IDLE;
            kind_q     <= K_ST;
            base_q     <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            io_q       <= 1'b0;
            starve_q   <= '0;
            buf_q      <= '0;
            mem_rw_q   <= 1'b0;
            mem_dout_q <= '0;
            mem_aout_q <= '0;
            st_done_q  <= 1'b0;
            ld_done_q  <= 1'b0;
            if_done_q  <= 1'b0;
            ld_rdata_q <= '0;
            if_rdata_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            base_q     <= base_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            io_q       <= io_d;
            starve_q   <= starve_d;
            buf_q      <= buf_d;
            mem_rw_q   <= mem_rw_d;
            mem_dout_q <= mem_dout_d;
            mem_aout_q <= mem_aout_d;
            st_done_q  <= st_done_d;
            ld_done_q  <= ld_done_d;
            if_done_q  <= if_done_d;
            ld_rdata_q <= ld_rdata_d;
            if_rdata_q <= if_rdata_d;
        end
    end

    // A full UART buffer suppresses the write strobe in the same cycle
    assign mem_rw   = mem_rw_q && !((state_q == WR) && io_q && io_buffer_full);
    assign mem_dout = mem_dout_q;
    assign mem_aout = mem_aout_q;
    assign st_done  = st_done_q;
    assign ld_done  = ld_done_q;
    assign if_done  = if_done_q;
    assign ld_rdata = ld_rdata_q;
    assign if_rdata = if_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: load, IO-stalled store, priority order,
// starvation, paused refill, width-3 load and reset mid-burst.
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst_in, rdy_in, io_buffer_full;
    logic [7:0]   mem_din;
    logic         mem_rw;
    logic [7:0]   mem_dout;
    logic [31:0]  mem_aout;
    logic         st_req, ld_req, if_req;
    logic [1:0]   lsb_width;
    logic [31:0]  lsb_addr, lsb_wdata, if_addr;
    logic         st_done, ld_done, if_done;
    logic [31:0]  ld_rdata;
    logic [511:0] if_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.BLK_BYTES(64), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_rw(mem_rw), .mem_dout(mem_dout), .mem_aout(mem_aout),
        .st_req(st_req), .ld_req(ld_req), .lsb_width(lsb_width), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .st_done(st_done), .ld_done(ld_done), .ld_rdata(ld_rdata),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata)
    );

    // RAM contents as a function of address; the RAM stalls with the system
    function automatic logic [7:0] ram_fn(input logic [31:0] a);
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            default: return a[7:0];
        endcase
    endfunction

    always @(posedge clk) if (rdy_in) mem_din <= ram_fn(mem_aout);

    function automatic logic [511:0] blk(input logic [7:0] start);
        logic [511:0] r;
        for (int k = 0; k < 64; k++) r[8*k +: 8] = start + 8'(k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st_c, ld_c, if_c, st_n, ld_n, if_n, ld_first, sdone, idone, peak, idc, ldseen;
        rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
        st_req = 1'b0; ld_req = 1'b0; if_req = 1'b0;
        lsb_width = 2'd0; lsb_addr = '0; lsb_wdata = '0; if_addr = '0;
        next(); next(); #1;
        chk("rst_rw", mem_rw, 0);
        chk("rst_aout", mem_aout, 0);
        chk("rst_dout", mem_dout, 0);
        chk("rst_dones", {st_done, ld_done, if_done}, 0);
        chk("rst_ldata", ld_rdata, 0);
        chk("rst_idata", if_rdata, 0);
        chk("rst_state", dut.state_q, 0);
        chk("rst_starve", dut.starve_q, 0);

        // load word from 0x100
        next(); rst_in = 1'b0;
        ld_req = 1'b1; lsb_width = 2'd2; lsb_addr = 32'h100;
        for (int c = 1; c <= 7; c++) begin
            next(); #1;
            if (c <= 4) begin
                chk("ld_aout", mem_aout, 32'h100 + 32'(c - 1));
                chk("ld_rw", mem_rw, 0);
            end
            if (c == 5) chk("ld_aout_zero", mem_aout, 0);
            if (c < 6) chk("ld_done_early", ld_done, 0);
            if (c == 6) begin
                chk("ld_done", ld_done, 1);
                chk("ld_rdata", ld_rdata, 32'h44332211);
                ld_req = 1'b0;
            end
            if (c == 7) begin
                chk("ld_done_pulse", ld_done, 0);
                chk("ld_rdata_hold", ld_rdata, 32'h44332211);
            end
        end

        // IO store with UART buffer full in cycles 1-3
        next();
        st_req = 1'b1; lsb_width = 2'd0; lsb_addr = 32'h30000; lsb_wdata = 32'h41;
        for (int c = 1; c <= 6; c++) begin
            next(); io_buffer_full = (c <= 3); #1;
            if (c <= 3) chk("io_stall_rw", mem_rw, 0);
            if (c == 4) begin
                chk("io_wr_rw", mem_rw, 1);
                chk("io_wr_aout", mem_aout, 32'h30000);
                chk("io_wr_dout", mem_dout, 8'h41);
                chk("io_st_early", st_done, 0);
            end
            if (c == 5) begin
                chk("io_st_done", st_done, 1);
                chk("io_done_rw", mem_rw, 0);
                st_req = 1'b0;
            end
            if (c == 6) chk("io_st_pulse", st_done, 0);
        end

        // simultaneous requests; non-IO store must ignore io_buffer_full
        next();
        st_req = 1'b1; ld_req = 1'b1; if_req = 1'b1; io_buffer_full = 1'b1;
        lsb_addr = 32'h100; lsb_width = 2'd1; lsb_wdata = 32'h0000BEEF; if_addr = 32'h0;
        st_c = -1; ld_c = -1; if_c = -1; st_n = 0; ld_n = 0; if_n = 0; ld_first = -1;
        for (int c = 1; c <= 90; c++) begin
            next(); #1;
            if (c == 1) chk("pr_wr0", {mem_rw, mem_aout, mem_dout}, {1'b1, 32'h100, 8'hEF});
            if (c == 2) chk("pr_wr1", {mem_rw, mem_aout, mem_dout}, {1'b1, 32'h101, 8'hBE});
            if (ld_first < 0 && st_c >= 0 && !mem_rw && mem_aout == 32'h100) ld_first = c;
            if (st_done) begin st_n++; if (st_c < 0) st_c = c; st_req = 1'b0; end
            if (ld_done) begin ld_n++; if (ld_c < 0) ld_c = c; ld_req = 1'b0; end
            if (if_done) begin if_n++; if (if_c < 0) if_c = c; if_req = 1'b0; end
        end
        io_buffer_full = 1'b0;
        chk("pr_st_cycle", st_c, 3);
        chk("pr_ld_first_addr", ld_first, 5);
        chk("pr_ld_cycle", ld_c, 8);
        chk("pr_if_cycle", if_c, 75);
        chk("pr_pulse_counts", {st_n, ld_n, if_n}, {32'd1, 32'd1, 32'd1});
        chk("pr_ld_rdata", ld_rdata, 32'h00002211);
        chk("pr_if_rdata", if_rdata, blk(8'h00));
        chk("pr_starve", dut.starve_q, 0);

        // starvation: store re-requests continuously while refill waits
        next();
        st_req = 1'b1; lsb_width = 2'd0; lsb_addr = 32'h300; lsb_wdata = 32'h5A;
        if_req = 1'b1; if_addr = 32'h40;
        sdone = 0; idone = -1; peak = 0;
        for (int c = 1; c <= 150; c++) begin
            next(); #1;
            if (int'(dut.starve_q) > peak) peak = int'(dut.starve_q);
            if (idone < 0 && st_done) sdone++;
            if (if_done && idone < 0) begin
                idone = c;
                chk("sv_starve_cleared", dut.starve_q, 0);
                chk("sv_if_rdata", if_rdata, blk(8'h40));
                st_req = 1'b0; if_req = 1'b0;
            end
        end
        chk("sv_lsb_grants", sdone, 4);
        chk("sv_peak", peak, 4);
        chk("sv_if_cycle", idone, 78);

        // refill from 0 with rdy_in low in cycles 20-24
        next();
        if_req = 1'b1; if_addr = 32'h0;
        idc = -1;
        for (int c = 1; c <= 80; c++) begin
            next(); rdy_in = !(c >= 20 && c <= 24); #1;
            if (c == 22) chk("rf_freeze_aout", mem_aout, 19);
            if (c == 25) chk("rf_resume_aout", mem_aout, 19);
            if (c == 26) chk("rf_advance_aout", mem_aout, 20);
            if (c == 66) chk("rf_not_early", if_done, 0);
            if (if_done && idc < 0) begin idc = c; if_req = 1'b0; end
        end
        chk("rf_done_cycle", idc, 71);
        chk("rf_rdata", if_rdata, blk(8'h00));

        // width 3 behaves as 4 bytes
        next();
        ld_req = 1'b1; lsb_width = 2'd3; lsb_addr = 32'h101;
        for (int c = 1; c <= 6; c++) begin
            next(); #1;
            if (c == 4) chk("w3_aout", mem_aout, 32'h104);
            if (c == 6) begin
                chk("w3_done", ld_done, 1);
                chk("w3_rdata", ld_rdata, 32'h04443322);
                ld_req = 1'b0;
            end
        end

        // reset in cycle 3 of a load
        next();
        ld_req = 1'b1; lsb_width = 2'd2; lsb_addr = 32'h100;
        ldseen = 0;
        for (int c = 1; c <= 15; c++) begin
            next(); rst_in = (c == 3); if (c == 3) ld_req = 1'b0; #1;
            if (ld_done) ldseen++;
            if (c == 3) chk("ra_mid_aout", mem_aout, 32'h102);
            if (c == 4) begin
                chk("ra_outs", {mem_rw, mem_aout, mem_dout, st_done, ld_done, if_done}, 0);
                chk("ra_ldata", ld_rdata, 0);
                chk("ra_idata", if_rdata, 0);
                chk("ra_state", dut.state_q, 0);
            end
        end
        chk("ra_no_done", ldseen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
